input_vc_buffer: RTL

//  Per-input-port virtual-channel buffer of a RaveNoC router. Sits directly upstream of

---
 rtl/ravenoc_pkg.sv | 18 +
 rtl/input_vc_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared RaveNoC router types.
//   NumVirtChn   number of virtual channels per link
//   FlitWidth    flit payload width
//   VcWidth      bits needed to name a VC
//   s_flit_req_t flit request: valid, vc_id, fdata
package ravenoc_pkg;

    localparam int NumVirtChn = 3;
    localparam int FlitWidth  = 32;
    localparam int VcWidth    = $clog2(NumVirtChn);

    typedef struct packed {
        logic                 valid;
        logic [VcWidth-1:0]   vc_id;
        logic [FlitWidth-1:0] fdata;
    } s_flit_req_t;

endpackage

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-input-port virtual-channel buffer of a RaveNoC router.
// Stores incoming flits in one FIFO per VC. It presents one flit per cycle, first-word
// fall-through, to input_router. The highest non-empty VC wins at every flit boundary.
// Once a flit is offered and not accepted, the choice is locked until it is accepted.
//   clk           clock, rising edge
//   arst          asynchronous reset, active-high
//   flit_req_i    incoming flit (valid, vc_id, fdata)
//   vc_ready_o    per-VC ready; set when that VC FIFO is not full
//   flit_req_o    flit offered to input_router
//   flit_ready_i  input_router accepts flit_req_o this cycle
//   overflow_o    one-cycle pulse after a write to a full VC was dropped
//   vc_empty_o    per-VC FIFO empty
module input_vc_buffer
    import ravenoc_pkg::*;
#(
    parameter int BUFF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  s_flit_req_t           flit_req_i,
    output logic [NumVirtChn-1:0] vc_ready_o,
    output s_flit_req_t           flit_req_o,
    input  logic                  flit_ready_i,
    output logic                  overflow_o,
    output logic [NumVirtChn-1:0] vc_empty_o
);

    localparam int PtrW = $clog2(BUFF_DEPTH);
    localparam int CntW = PtrW + 1;

    typedef logic [VcWidth-1:0] vc_t;
    typedef enum logic {IDLE, LOCKED} state_t;

    logic [FlitWidth-1:0]  mem    [NumVirtChn][BUFF_DEPTH];
    logic [PtrW-1:0]       wr_ptr [NumVirtChn];
    logic [PtrW-1:0]       rd_ptr [NumVirtChn];
    logic [CntW-1:0]       count  [NumVirtChn];

    logic [NumVirtChn-1:0] full;
    logic [NumVirtChn-1:0] empty;
    logic [NumVirtChn-1:0] push;
    logic [NumVirtChn-1:0] pop;
    logic [NumVirtChn-1:0] drop;

    state_t state, state_nxt;
    vc_t    lock_vc, lock_vc_nxt;
    vc_t    hi_vc;
    vc_t    sel;
    logic   out_valid;

    // Per-VC status and handshakes. Ready comes from registered count only, so a
    // full VC refuses a write even when it is being popped in the same cycle.
    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        drop  = '0;
        for (int v = 0; v < NumVirtChn; v++) begin
            full[v]  = (count[v] == CntW'(BUFF_DEPTH));
            empty[v] = (count[v] == '0);
            push[v]  = flit_req_i.valid && (flit_req_i.vc_id == vc_t'(v)) && !full[v];
            drop[v]  = flit_req_i.valid && (flit_req_i.vc_id == vc_t'(v)) && full[v];
            pop[v]   = out_valid && flit_ready_i && (sel == vc_t'(v));
        end
    end

    // Highest-index non-empty VC; later iterations overwrite earlier ones.
    always_comb begin
        hi_vc = '0;
        for (int v = 0; v < NumVirtChn; v++) begin
            if (!empty[v]) hi_vc = vc_t'(v);
        end
    end

    // Selection FSM. LOCKED keeps an offered-but-unaccepted flit stable, which blocks
    // preemption until the handshake completes.
    always_comb begin
        state_nxt   = state;
        lock_vc_nxt = lock_vc;
        sel         = hi_vc;
        out_valid   = |(~empty);
        case (state)
            IDLE: begin
                if (out_valid && !flit_ready_i) begin
                    state_nxt   = LOCKED;
                    lock_vc_nxt = hi_vc;
                end
            end
            LOCKED: begin
                sel       = lock_vc;
                out_valid = 1'b1;
                if (flit_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            lock_vc    <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_vc    <= lock_vc_nxt;
            overflow_o <= |drop;
        end
    end

    // Pointers wrap naturally because BUFF_DEPTH is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < NumVirtChn; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NumVirtChn; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                count[v] <= count[v] + CntW'(push[v]) - CntW'(pop[v]);
            end
        end
    end

    // Flit storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NumVirtChn; v++) begin
            if (push[v]) mem[v][wr_ptr[v]] <= flit_req_i.fdata;
        end
    end

    // vc_id and fdata are forced to zero while nothing is offered. This yields the
    // reset value and fills the don't-care cycles deterministically.
    always_comb begin
        flit_req_o       = '0;
        flit_req_o.valid = out_valid;
        if (out_valid) begin
            flit_req_o.vc_id = sel;
            flit_req_o.fdata = mem[sel][rd_ptr[sel]];
        end
    end

    assign vc_ready_o = ~full;
    assign vc_empty_o = empty;

endmodule
